// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: single-port word memory behind a burst command interface.
// A command (write or read, start address, beats-1) is taken in IDLE. A write
// burst then consumes write beats one per wvalid_i. A read burst streams words
// out with a one-cycle memory latency and rvalid_o/rready_i backpressure.
// Addresses wrap modulo DEPTH.
// Optional feature macro: MEM_BYTE_STROBE_EN. When defined, wstrb_i selects
// which bytes of a write beat land in memory. When undefined, whole words are
// written and wstrb_i is ignored.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holding valid keeps its payload stable until it is taken.
module mem_burst_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  rlast_o,
    input  logic                  rready_i,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        RDRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  wr_beat;
    logic                  rd_issue;

    // wready_o is only ever high in WRITE, so it doubles as the write qualifier.
    assign wr_beat     = wready_o && wvalid_i;
    // A read beat may be issued when the output slot is empty or being drained.
    assign rd_issue    = (state == READ) && (!rvalid_o || rready_i);
    assign dbg_state_o = state;

`ifndef MEM_BYTE_STROBE_EN
    logic unused_strb;
    assign unused_strb = ^wstrb_i;
`endif

    // Memory write port; the array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_beat) begin
`ifdef MEM_BYTE_STROBE_EN
            for (int k = 0; k < WIDTH/8; k++) begin
                if (wstrb_i[k]) begin
                    mem[ptr][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
`else
            mem[ptr] <= wdata_i;
`endif
        end
    end

    // Burst control FSM with registered handshake and read-data outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ready_o  <= 1'b1;
            wready_o <= 1'b0;
            busy_o   <= 1'b0;
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
            rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        ptr      <= addr_i;
                        cnt      <= len_i;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b1;
                        wready_o <= wr_rd_i;
                        state    <= wr_rd_i ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        ptr <= ptr + 1'b1;
                        if (cnt == '0) begin
                            state    <= IDLE;
                            wready_o <= 1'b0;
                            busy_o   <= 1'b0;
                            ready_o  <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        rdata_o  <= mem[ptr];
                        rvalid_o <= 1'b1;
                        rlast_o  <= (cnt == '0);
                        ptr      <= ptr + 1'b1;
                        if (cnt == '0) begin
                            state <= RDRAIN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                RDRAIN: begin
                    if (rvalid_o && rready_i) begin
                        rvalid_o <= 1'b0;
                        rlast_o  <= 1'b0;
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Testbench for mem_burst_ctrl: shadow memory plus expected-read queue.
module tb_mem_burst_ctrl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LW    = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic            ready;
    logic            wr_rd = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [LW-1:0]   len = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic [1:0]      wstrb = 2'b11;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [WIDTH-1:0] rdata;
    logic            rvalid;
    logic            rlast;
    logic            rready = 1'b0;
    logic            busy;
    logic [1:0]      dbg_state;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] wbuf [8];
    logic [WIDTH-1:0] exp_q [$];

    mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
        .wr_rd_i(wr_rd), .addr_i(addr), .len_i(len), .wdata_i(wdata),
        .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready), .rdata_o(rdata),
        .rvalid_o(rvalid), .rlast_o(rlast), .rready_i(rready), .busy_o(busy),
        .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // Present one command at the current negedge; it is taken on the next posedge.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input int l);
        valid = 1'b1;
        wr_rd = wr;
        addr  = a;
        len   = l[LW-1:0];
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready: got %b expected 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Write burst from wbuf, with 'gap' idle cycles before every beat but the first.
    task automatic do_write(input logic [AW-1:0] a, input int l, input int gap, input logic [1:0] strb);
        logic [AW-1:0] idx;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= l; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    wvalid = 1'b0;
                    wdata  = ~wbuf[i];
                    @(negedge clk);
                    checks++;
                    if (busy !== 1'b1 || wready !== 1'b1) begin
                        failures++;
                        $display("FAIL gap_busy_wready: got busy=%b wready=%b expected 1 1", busy, wready);
                    end
                end
            end
            wvalid = 1'b1;
            wdata  = wbuf[i];
            wstrb  = strb;
            checks++;
            if (wready !== 1'b1) begin
                failures++;
                $display("FAIL wready_beat%0d: got %b expected 1", i, wready);
            end
            @(negedge clk);
            idx = a + AW'(i);
`ifdef MEM_BYTE_STROBE_EN
            for (int k = 0; k < WIDTH/8; k++) begin
                if (strb[k]) model_mem[idx][8*k +: 8] = wbuf[i][8*k +: 8];
            end
`else
            model_mem[idx] = wbuf[i];
`endif
        end
        wvalid = 1'b0;
        wstrb  = 2'b11;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL write_end: got ready=%b busy=%b wready=%b expected 1 0 0", ready, busy, wready);
        end
    endtask

    // Read burst; expected words come from the shadow memory. Beat number
    // stall_beat (0-based) is held off with rready low for stall_cyc cycles.
    task automatic do_read(input logic [AW-1:0] a, input int l, input int stall_beat, input int stall_cyc);
        int got, cyc, first_cyc, last_cyc, stall_left;
        logic [WIDTH-1:0] held, exp;
        logic holding;
        logic [AW-1:0] idx;
        for (int i = 0; i <= l; i++) begin
            idx = a + AW'(i);
            exp_q.push_back(model_mem[idx]);
        end
        rready = 1'b1;
        send_cmd(1'b0, a, l);
        got = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
        stall_left = stall_cyc; holding = 1'b0; held = '0;
        while (got <= l && cyc < 100) begin
            if (rvalid) begin
                if (holding) begin
                    checks++;
                    if (rdata !== held) begin
                        failures++;
                        $display("FAIL stall_hold: got %h expected %h", rdata, held);
                    end
                end
                if (got == stall_beat && stall_left > 0) begin
                    held = rdata; holding = 1'b1; rready = 1'b0; stall_left--;
                end else begin
                    holding = 1'b0;
                    rready = 1'b1;
                    exp = exp_q.pop_front();
                    checks++;
                    if (rdata !== exp) begin
                        failures++;
                        $display("FAIL rdata_beat%0d: got %h expected %h", got, rdata, exp);
                    end
                    checks++;
                    if (rlast !== (got == l)) begin
                        failures++;
                        $display("FAIL rlast_beat%0d: got %b expected %b", got, rlast, (got == l));
                    end
                    if (got == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    got++;
                end
            end else begin
                rready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got <= l) begin
            failures++;
            $display("FAIL read_timeout: got %0d beats expected %0d", got, l + 1);
            exp_q.delete();
        end
        checks++;
        if (last_cyc - first_cyc != l + stall_cyc) begin
            failures++;
            $display("FAIL read_span: got %0d cycles expected %0d", last_cyc - first_cyc, l + stall_cyc);
        end
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_end: got rvalid=%b rlast=%b ready=%b busy=%b expected 0 0 1 0",
                     rvalid, rlast, ready, busy);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = WIDTH'($urandom_range(0, 65535));
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (wready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || busy !== 1'b0 ||
            rdata !== '0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got wready=%b rvalid=%b rlast=%b busy=%b rdata=%h state=%0d expected 0 0 0 0 0000 0",
                     wready, rvalid, rlast, busy, rdata, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", ready, busy);
        end
    endtask

    task automatic test_basic;
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        do_write(9'd5, 3, 0, 2'b11);
        do_read(9'd5, 3, -1, 0);
    endtask

    task automatic test_wrap;
        fill_random(4);
        do_write(9'd510, 3, 0, 2'b11);
        do_read(9'd510, 3, -1, 0);
    endtask

    task automatic test_max_len;
        fill_random(8);
        do_write(9'd250, 7, 0, 2'b11);
        do_read(9'd250, 7, -1, 0);
    endtask

    task automatic test_backpressure;
        fill_random(3);
        do_write(9'd300, 2, 0, 2'b11);
        do_read(9'd300, 2, 1, 3);
    endtask

    task automatic test_wvalid_gaps;
        fill_random(4);
        do_write(9'd40, 3, 2, 2'b11);
        do_read(9'd40, 3, -1, 0);
    endtask

    task automatic test_idle_ignore;
        fill_random(2);
        do_write(9'd60, 1, 0, 2'b11);
        do_read(9'd60, 0, -1, 0);
        wvalid = 1'b1;
        wdata  = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wready !== 1'b0) begin
                failures++;
                $display("FAIL idle_wready: got %b expected 0", wready);
            end
        end
        wvalid = 1'b0;
        do_read(9'd60, 1, -1, 0);
    endtask

    task automatic test_strobe;
        wbuf[0] = 16'hABCD;
        do_write(9'd100, 0, 0, 2'b11);
        wbuf[0] = 16'h1234;
        do_write(9'd100, 0, 0, 2'b01);
        do_read(9'd100, 0, -1, 0);
    endtask

    task automatic test_reset_mid_burst;
        logic [WIDTH-1:0] newv [4];
        fill_random(4);
        do_write(9'd200, 3, 0, 2'b11);
        for (int i = 0; i < 4; i++) newv[i] = ~wbuf[i];
        send_cmd(1'b1, 9'd200, 3);
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wdata  = newv[i];
            @(negedge clk);
            model_mem[9'd200 + AW'(i)] = newv[i];
        end
        wdata = newv[2];
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || busy !== 1'b0 ||
            rdata !== '0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: got wready=%b rvalid=%b rlast=%b busy=%b rdata=%h state=%0d expected 0 0 0 0 0000 0",
                     wready, rvalid, rlast, busy, rdata, dbg_state);
        end
        wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(9'd200, 3, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_max_len();
        test_backpressure();
        test_wvalid_gaps();
        test_idle_ignore();
        test_strobe();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
